// File: rtl/l2_cache_dir.sv
// L2 directory stage: way hit detection, per-set/per-way dirty bits, victim writeback
// decision, and one-cycle registration of the request for the data stage.
module l2_cache_dir #(
    parameter int unsigned NUM_SETS        = 128,
    parameter int unsigned SET_INDEX_WIDTH = 7,
    parameter int unsigned TAG_WIDTH       = 19
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 stall_pipeline_i,
    input  logic                 tag_l2req_valid_i,
    input  logic [1:0]           tag_l2req_core_i,
    input  logic [1:0]           tag_l2req_unit_i,
    input  logic [1:0]           tag_l2req_strand_i,
    input  logic [2:0]           tag_l2req_op_i,
    input  logic [1:0]           tag_l2req_way_i,
    input  logic [25:0]          tag_l2req_address_i,
    input  logic [511:0]         tag_l2req_data_i,
    input  logic [63:0]          tag_l2req_mask_i,
    input  logic                 tag_has_sm_data_i,
    input  logic [511:0]         tag_sm_data_i,
    input  logic [1:0]           tag_sm_fill_l2_way_i,
    input  logic [1:0]           tag_replace_l2_way_i,
    input  logic [TAG_WIDTH-1:0] tag_l2_tag0_i,
    input  logic [TAG_WIDTH-1:0] tag_l2_tag1_i,
    input  logic [TAG_WIDTH-1:0] tag_l2_tag2_i,
    input  logic [TAG_WIDTH-1:0] tag_l2_tag3_i,
    input  logic                 tag_l2_valid0_i,
    input  logic                 tag_l2_valid1_i,
    input  logic                 tag_l2_valid2_i,
    input  logic                 tag_l2_valid3_i,
    output logic                 dir_l2req_valid_o,
    output logic [1:0]           dir_l2req_core_o,
    output logic [1:0]           dir_l2req_unit_o,
    output logic [1:0]           dir_l2req_strand_o,
    output logic [2:0]           dir_l2req_op_o,
    output logic [1:0]           dir_l2req_way_o,
    output logic [25:0]          dir_l2req_address_o,
    output logic [511:0]         dir_l2req_data_o,
    output logic [63:0]          dir_l2req_mask_o,
    output logic                 dir_has_sm_data_o,
    output logic [511:0]         dir_sm_data_o,
    output logic [1:0]           dir_sm_fill_l2_way_o,
    output logic [1:0]           dir_replace_l2_way_o,
    output logic                 dir_cache_hit_o,
    output logic [1:0]           dir_hit_l2_way_o,
    output logic                 dir_need_writeback_o,
    output logic [TAG_WIDTH-1:0] dir_old_l2_tag_o
);

    localparam logic [2:0] OpStore      = 3'd1;
    localparam logic [2:0] OpFlush      = 3'd2;
    localparam logic [2:0] OpInvalidate = 3'd3;
    localparam logic [2:0] OpStoreSync  = 3'd5;

    logic [SET_INDEX_WIDTH-1:0] set_idx;
    logic [TAG_WIDTH-1:0]       req_tag;
    logic [TAG_WIDTH-1:0]       way_tag [4];
    logic [3:0]                 way_valid;
    logic [3:0]                 hit_vec;
    logic                       hit;
    logic [1:0]                 hit_way;
    logic                       is_store;
    logic                       is_clean_op;

    logic [NUM_SETS-1:0][3:0] dirty_q, dirty_d;
    logic                     cache_hit_d;
    logic [1:0]               hit_l2_way_d;
    logic                     need_writeback_d;
    logic [TAG_WIDTH-1:0]     old_l2_tag_d;

    assign set_idx   = tag_l2req_address_i[SET_INDEX_WIDTH-1:0];
    assign req_tag   = tag_l2req_address_i[TAG_WIDTH+SET_INDEX_WIDTH-1:SET_INDEX_WIDTH];
    assign way_tag[0] = tag_l2_tag0_i;
    assign way_tag[1] = tag_l2_tag1_i;
    assign way_tag[2] = tag_l2_tag2_i;
    assign way_tag[3] = tag_l2_tag3_i;
    assign way_valid = {tag_l2_valid3_i, tag_l2_valid2_i, tag_l2_valid1_i, tag_l2_valid0_i};
    assign is_store    = (tag_l2req_op_i == OpStore) || (tag_l2req_op_i == OpStoreSync);
    assign is_clean_op = (tag_l2req_op_i == OpFlush) || (tag_l2req_op_i == OpInvalidate);

    always_comb begin
        hit_way = 2'd0;
        for (int i = 0; i < 4; i++) begin
            hit_vec[i] = way_valid[i] && (way_tag[i] == req_tag);
        end
        // Descending scan so the lowest matching way wins on a (illegal) multi-hit.
        for (int i = 3; i >= 0; i--) begin
            if (hit_vec[i]) hit_way = 2'(i);
        end
        hit = |hit_vec;
    end

    always_comb begin
        dirty_d = dirty_q;
        if (tag_has_sm_data_i) begin
            cache_hit_d      = 1'b1;
            hit_l2_way_d     = tag_sm_fill_l2_way_i;
            need_writeback_d = way_valid[tag_sm_fill_l2_way_i]
                               && dirty_q[set_idx][tag_sm_fill_l2_way_i];
            old_l2_tag_d     = way_tag[tag_sm_fill_l2_way_i];
        end else begin
            cache_hit_d      = hit;
            hit_l2_way_d     = hit_way;
            need_writeback_d = hit && (tag_l2req_op_i == OpFlush) && dirty_q[set_idx][hit_way];
            old_l2_tag_d     = req_tag;
        end

        if (tag_l2req_valid_i) begin
            if (tag_has_sm_data_i) begin
                dirty_d[set_idx][tag_sm_fill_l2_way_i] = is_store;
            end else if (hit && is_store) begin
                dirty_d[set_idx][hit_way] = 1'b1;
            end else if (hit && is_clean_op) begin
                dirty_d[set_idx][hit_way] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dirty_q              <= '0;
            dir_l2req_valid_o    <= 1'b0;
            dir_l2req_core_o     <= '0;
            dir_l2req_unit_o     <= '0;
            dir_l2req_strand_o   <= '0;
            dir_l2req_op_o       <= '0;
            dir_l2req_way_o      <= '0;
            dir_l2req_address_o  <= '0;
            dir_l2req_data_o     <= '0;
            dir_l2req_mask_o     <= '0;
            dir_has_sm_data_o    <= 1'b0;
            dir_sm_data_o        <= '0;
            dir_sm_fill_l2_way_o <= '0;
            dir_replace_l2_way_o <= '0;
            dir_cache_hit_o      <= 1'b0;
            dir_hit_l2_way_o     <= '0;
            dir_need_writeback_o <= 1'b0;
            dir_old_l2_tag_o     <= '0;
        end else if (!stall_pipeline_i) begin
            dirty_q              <= dirty_d;
            dir_l2req_valid_o    <= tag_l2req_valid_i;
            dir_l2req_core_o     <= tag_l2req_core_i;
            dir_l2req_unit_o     <= tag_l2req_unit_i;
            dir_l2req_strand_o   <= tag_l2req_strand_i;
            dir_l2req_op_o       <= tag_l2req_op_i;
            dir_l2req_way_o      <= tag_l2req_way_i;
            dir_l2req_address_o  <= tag_l2req_address_i;
            dir_l2req_data_o     <= tag_l2req_data_i;
            dir_l2req_mask_o     <= tag_l2req_mask_i;
            dir_has_sm_data_o    <= tag_has_sm_data_i;
            dir_sm_data_o        <= tag_sm_data_i;
            dir_sm_fill_l2_way_o <= tag_sm_fill_l2_way_i;
            dir_replace_l2_way_o <= tag_replace_l2_way_i;
            dir_cache_hit_o      <= cache_hit_d;
            dir_hit_l2_way_o     <= hit_l2_way_d;
            dir_need_writeback_o <= need_writeback_d;
            dir_old_l2_tag_o     <= old_l2_tag_d;
        end
    end

`ifndef SYNTHESIS
    a_single_hit: assert property (@(posedge clk_i) disable iff (reset_i)
        tag_l2req_valid_i |-> $onehot0(hit_vec))
        else $error("multiple ways hit");
    a_fill_op: assert property (@(posedge clk_i) disable iff (reset_i)
        (tag_l2req_valid_i && tag_has_sm_data_i) |-> !is_clean_op)
        else $error("restart with flush/invalidate");
`endif

endmodule

// File: tb/tb_l2_cache_dir.sv
// Randomized and directed bench for l2_cache_dir against a behavioural directory model.
module tb_l2_cache_dir;

    localparam logic [2:0] LOAD = 3'd0, STORE = 3'd1, FLUSH = 3'd2;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall;
    logic         valid;
    logic [1:0]   core, unit, strand, rway;
    logic [2:0]   op;
    logic [25:0]  addr;
    logic [511:0] data, sm_data;
    logic [63:0]  mask;
    logic         has_sm;
    logic [1:0]   fill, repl;
    logic [18:0]  wtag [4];
    logic         wval [4];

    logic         o_valid, o_has_sm, o_hit, o_wb;
    logic [1:0]   o_core, o_unit, o_strand, o_rway, o_fill, o_repl, o_way;
    logic [2:0]   o_op;
    logic [25:0]  o_addr;
    logic [511:0] o_data, o_sm_data;
    logic [63:0]  o_mask;
    logic [18:0]  o_old;

    // Reference state: dirty flags per set/way and the expected registered outputs.
    bit           mdirty [128][4];
    logic [613:0] e_req;
    logic [516:0] e_sm;
    logic         e_hit, e_wb;
    logic [1:0]   e_way;
    logic [18:0]  e_old;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    l2_cache_dir dut (
        .clk_i(clk), .reset_i(reset), .stall_pipeline_i(stall),
        .tag_l2req_valid_i(valid), .tag_l2req_core_i(core), .tag_l2req_unit_i(unit),
        .tag_l2req_strand_i(strand), .tag_l2req_op_i(op), .tag_l2req_way_i(rway),
        .tag_l2req_address_i(addr), .tag_l2req_data_i(data), .tag_l2req_mask_i(mask),
        .tag_has_sm_data_i(has_sm), .tag_sm_data_i(sm_data),
        .tag_sm_fill_l2_way_i(fill), .tag_replace_l2_way_i(repl),
        .tag_l2_tag0_i(wtag[0]), .tag_l2_tag1_i(wtag[1]),
        .tag_l2_tag2_i(wtag[2]), .tag_l2_tag3_i(wtag[3]),
        .tag_l2_valid0_i(wval[0]), .tag_l2_valid1_i(wval[1]),
        .tag_l2_valid2_i(wval[2]), .tag_l2_valid3_i(wval[3]),
        .dir_l2req_valid_o(o_valid), .dir_l2req_core_o(o_core), .dir_l2req_unit_o(o_unit),
        .dir_l2req_strand_o(o_strand), .dir_l2req_op_o(o_op), .dir_l2req_way_o(o_rway),
        .dir_l2req_address_o(o_addr), .dir_l2req_data_o(o_data), .dir_l2req_mask_o(o_mask),
        .dir_has_sm_data_o(o_has_sm), .dir_sm_data_o(o_sm_data),
        .dir_sm_fill_l2_way_o(o_fill), .dir_replace_l2_way_o(o_repl),
        .dir_cache_hit_o(o_hit), .dir_hit_l2_way_o(o_way),
        .dir_need_writeback_o(o_wb), .dir_old_l2_tag_o(o_old)
    );

    task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        e_req = '0; e_sm = '0; e_hit = 1'b0; e_wb = 1'b0; e_way = '0; e_old = '0;
        for (int s = 0; s < 128; s++)
            for (int w = 0; w < 4; w++) mdirty[s][w] = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {o_valid, o_core, o_unit, o_strand, o_op, o_rway, o_addr, o_data, o_mask,
                    o_has_sm, o_sm_data, o_fill, o_repl, o_hit, o_way, o_wb, o_old}, '0);
    endtask

    // Predict from the current inputs, clock once, then compare every output.
    task automatic step();
        int   s, hw;
        bit   hit, st;
        logic [18:0] rt;
        s  = int'(addr[6:0]);
        rt = addr[25:7];
        hit = 1'b0; hw = 0;
        for (int w = 0; w < 4; w++)
            if (!hit && wval[w] && wtag[w] == rt) begin hit = 1'b1; hw = w; end
        st = (op == 3'd1) || (op == 3'd5);
        if (!stall) begin
            e_req = {valid, core, unit, strand, op, rway, addr, data, mask};
            e_sm  = {has_sm, sm_data, fill, repl};
            if (has_sm) begin
                e_hit = 1'b1; e_way = fill; e_old = wtag[fill];
                e_wb  = wval[fill] && mdirty[s][fill];
            end else begin
                e_hit = hit; e_way = 2'(hw); e_old = rt;
                e_wb  = hit && op == FLUSH && mdirty[s][hw];
            end
            if (valid) begin
                if (has_sm) mdirty[s][fill] = st;
                else if (hit && st) mdirty[s][hw] = 1'b1;
                else if (hit && (op == 3'd2 || op == 3'd3)) mdirty[s][hw] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("req", {o_valid, o_core, o_unit, o_strand, o_op, o_rway, o_addr, o_data, o_mask},
              e_req);
        check("sm", {o_has_sm, o_sm_data, o_fill, o_repl}, e_sm);
        check("hit", o_hit, e_hit);
        check("way", o_way, e_way);
        check("wb", o_wb, e_wb);
        check("old_tag", o_old, e_old);
    endtask

    task automatic rand_payload();
        core = 2'($urandom); unit = 2'($urandom); strand = 2'($urandom); rway = 2'($urandom);
        for (int i = 0; i < 16; i++) begin
            data[i*32 +: 32]    = $urandom;
            sm_data[i*32 +: 32] = $urandom;
        end
        mask = {$urandom, $urandom};
    endtask

    task automatic req(input logic [2:0] o, input int s, input logic [18:0] t,
                       input logic sm, input logic [1:0] f, input logic [1:0] r);
        valid = 1'b1; op = o; addr = {t, 7'(s)}; has_sm = sm; fill = f; repl = r;
        rand_payload();
    endtask

    task automatic set_ways(input logic [18:0] t0, input logic [18:0] t1,
                            input logic [18:0] t2, input logic [18:0] t3);
        wtag[0] = t0; wtag[1] = t1; wtag[2] = t2; wtag[3] = t3;
        for (int w = 0; w < 4; w++) wval[w] = 1'b1;
    endtask

    task automatic pulse_reset(input string tag);
        #2 reset = 1'b1;
        #1 check_all_zero(tag);
        model_reset();
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; valid = 1'b0; op = '0; addr = '0; has_sm = 1'b0;
        fill = '0; repl = '0; core = '0; unit = '0; strand = '0; rway = '0;
        data = '0; sm_data = '0; mask = '0;
        set_ways(19'h10, 19'h11, 19'h100, 19'h13);
        model_reset();
        #12 check_all_zero("reset");
        @(negedge clk) reset = 1'b0;

        // Load hit on way 2.
        req(LOAD, 5, 19'h100, 1'b0, 2'd0, 2'd1); step();
        check("t1_hit", o_hit, 1'b1); check("t1_way", o_way, 2'd2); check("t1_wb", o_wb, 1'b0);

        // Store dirties the line, first flush writes back, second does not.
        req(STORE, 5, 19'h100, 1'b0, 2'd0, 2'd0); step();
        req(FLUSH, 5, 19'h100, 1'b0, 2'd0, 2'd0); step();
        check("t2_wb", o_wb, 1'b1); check("t2_old", o_old, 19'h100);
        req(FLUSH, 5, 19'h100, 1'b0, 2'd0, 2'd0); step();
        check("t2_wb2", o_wb, 1'b0);

        // Restart store over a clean victim, then restart load over the now-dirty one.
        set_ways(19'h20, 19'h7, 19'h22, 19'h23);
        req(STORE, 9, 19'h200, 1'b1, 2'd1, 2'd3); step();
        check("t3_wb", o_wb, 1'b0); check("t3_way", o_way, 2'd1); check("t3_hit", o_hit, 1'b1);
        wtag[1] = 19'h55;
        req(LOAD, 9, 19'h300, 1'b1, 2'd1, 2'd0); step();
        check("t3_wb2", o_wb, 1'b1); check("t3_old", o_old, 19'h55);
        wtag[1] = 19'h300;
        req(FLUSH, 9, 19'h300, 1'b0, 2'd0, 2'd0); step();
        check("t3_cleared", o_wb, 1'b0);

        // Store miss leaves dirty state alone.
        set_ways(19'h10, 19'h11, 19'h100, 19'h13);
        req(STORE, 5, 19'h999, 1'b0, 2'd0, 2'd3); step();
        check("t4_hit", o_hit, 1'b0); check("t4_repl", o_repl, 2'd3);
        req(FLUSH, 5, 19'h13, 1'b0, 2'd0, 2'd0); step();
        check("t4_wb", o_wb, 1'b0); check("t4_way", o_way, 2'd3);

        // Stalled store must neither move outputs nor dirty the line.
        req(LOAD, 7, 19'h100, 1'b0, 2'd0, 2'd0); step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req(STORE, 7, 19'h10, 1'b0, 2'd0, 2'd1); step();
            check("stall_way", o_way, 2'd2);
        end
        stall = 1'b0;
        req(FLUSH, 7, 19'h10, 1'b0, 2'd0, 2'd2); step();
        check("release_way", o_way, 2'd0); check("release_wb", o_wb, 1'b0);

        // Asynchronous reset clears outputs and dirty bits.
        req(STORE, 3, 19'h10, 1'b0, 2'd0, 2'd0); step();
        pulse_reset("rst_async");
        req(FLUSH, 3, 19'h10, 1'b0, 2'd0, 2'd0); step();
        check("t6_wb", o_wb, 1'b0); check("t6_hit", o_hit, 1'b1);

        // Reset while stalled.
        req(STORE, 3, 19'h11, 1'b0, 2'd0, 2'd0); step();
        stall = 1'b1;
        pulse_reset("rst_stall");
        stall = 1'b0;

        // Random traffic over a few sets so dirty state gets reused.
        for (int n = 0; n < 600; n++) begin
            int base;
            base = int'($urandom_range(0, 7));
            for (int w = 0; w < 4; w++) begin
                wtag[w] = 19'(base * 4 + w);
                wval[w] = ($urandom_range(0, 9) < 8);
            end
            has_sm = ($urandom_range(0, 4) == 0);
            op = has_sm ? ($urandom_range(0, 1) ? 3'd1 : 3'd0) + 3'($urandom_range(0, 1) * 4)
                        : 3'($urandom_range(0, 5));
            addr = {($urandom_range(0, 3) != 0) ? wtag[$urandom_range(0, 3)] : 19'h7FFFF,
                    7'($urandom_range(0, 3))};
            valid = ($urandom_range(0, 9) != 0);
            fill = 2'($urandom); repl = 2'($urandom);
            stall = ($urandom_range(0, 6) == 0);
            rand_payload();
            step();
            if ($urandom_range(0, 199) == 0) pulse_reset("rst_rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/l2_cache_dir.md
Name: l2_cache_dir

Overview:
- Directory stage of the L2 pipeline, directly downstream of the tag stage.
- Compares the request tag against the four way tags and valid bits read by the tag stage, producing hit/way.
- Owns the per-way, per-set dirty bits.
- Decides victim writeback on fills and on flush hits, then registers the request and results for the data/read stage.

Parameters:
- NUM_SETS, 128, number of L2 sets
- SET_INDEX_WIDTH, 7, log2(NUM_SETS); set = address[SET_INDEX_WIDTH-1:0]
- TAG_WIDTH, 19, tag = address[TAG_WIDTH+SET_INDEX_WIDTH-1:SET_INDEX_WIDTH]

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- stall_pipeline  in  1  hold all stage registers and dirty state
- tag_l2req_valid/core/unit/strand/op/way/address/data/mask  in  1/2/2/2/3/2/26/512/64  request from tag stage
- tag_has_sm_data  in  1  restarted request carrying a fill line
- tag_sm_data  in  512  fill line
- tag_sm_fill_l2_way  in  2  way being filled
- tag_replace_l2_way  in  2  LRU way for this set
- tag_l2_tag0..3  in  TAG_WIDTH each  way tags, pre-fill contents
- tag_l2_valid0..3  in  1 each  way valid bits, pre-fill contents
- dir_l2req_* (same nine fields), dir_has_sm_data, dir_sm_data, dir_sm_fill_l2_way, dir_replace_l2_way  out  as inputs  registered pass-through
- dir_cache_hit  out  1  request hit, or restart
- dir_hit_l2_way  out  2  hit way, or fill way on restart
- dir_need_writeback  out  1  victim/flushed line is dirty and must be written to memory
- dir_old_l2_tag  out  TAG_WIDTH  tag of the line to be written back

Behaviour:
- Op encodings: LOAD=0, STORE=1, FLUSH=2, INVALIDATE=3, LOAD_SYNC=4, STORE_SYNC=5. "Store" means op 1 or 5.
- Reset:
  - All outputs go to 0.
  - All NUM_SETS x 4 dirty bits are cleared, asynchronously.
- Advance:
  - advance = !stall_pipeline.
  - On a posedge with advance, every dir_* output loads its next value: pass-through fields copy the tag_* inputs.
  - Latency is exactly 1 cycle.
  - With stall, all outputs and dirty bits hold.
- Hit detect (combinational):
  - hit_i = tag_l2_valid_i && tag_l2_tag_i == request tag.
  - hit = OR of hit_i; hit way = encoded index.
  - Two or more hit_i set is an error: it fires an assertion, and the lowest index wins.
- Restart (tag_has_sm_data=1):
  - dir_cache_hit=1, dir_hit_l2_way=tag_sm_fill_l2_way.
  - victim = fill way.
  - dir_need_writeback = tag_l2_valid[fill] && dirty[fill][set].
  - dir_old_l2_tag = tag_l2_tag[fill].
- Non-restart:
  - dir_cache_hit=hit, dir_hit_l2_way=hit way.
  - dir_need_writeback = hit && op==FLUSH && dirty[hit way][set].
  - dir_old_l2_tag = request tag.
  - In all other cases, dir_need_writeback=0.
- Dirty array:
  - Flops; read combinationally at set = tag_l2req_address set index.
  - Updates only when advance && tag_l2req_valid.
  - Restart: dirty[fill][set] <= store.
  - Hit + store: dirty[hit way][set] <= 1.
  - Hit + FLUSH or INVALIDATE: dirty[hit way][set] <= 0.
  - Miss, or hit + load: no change.
- Back-to-back requests to the same set see the prior update; no bypass is needed, because updates land on the same edge the prior request leaves.
- When tag_l2req_valid=0, the computed fields still register but carry no meaning, and dirty state is unchanged.
- Assertion: tag_has_sm_data with FLUSH/INVALIDATE is an error.
- Reset during a stall clears everything; the held request is lost.

Test Plan:
- Reset, then load set 5, tag 0x100, way2 valid with tag 0x100 -> next cycle: dir_cache_hit=1, dir_hit_l2_way=2, dir_need_writeback=0.
- Store hit set 5 way2, then FLUSH of same address -> flush outputs dir_need_writeback=1 and dir_old_l2_tag=0x100; a second FLUSH gives dir_need_writeback=0.
- Restart store into set 9 way1 (old valid, tag 0x7, clean) -> dir_need_writeback=0, dir_hit_l2_way=1. Then restart load into way1 with old tag 0x55 -> dir_need_writeback=1, dir_old_l2_tag=0x55, and the dirty bit is cleared.
- Miss (no valid tag matches) with store op -> dir_cache_hit=0, dir_replace_l2_way equals input LRU way, no dirty change: a later flush hit gives no writeback.
- Hold stall_pipeline=1 for 3 cycles while inputs change -> outputs and dirty bits unchanged. Release -> the current inputs register.
- Assert reset mid-stream after dirtying set 3 way0 -> outputs become 0 immediately (asynchronously); a later flush hit on set 3 way0 gives dir_need_writeback=0.
